// File: rtl/axis_rr_input_arbiter_if.sv
// AXI-Stream bundle shared by the two ingress sources and the merged egress
// of the round-robin input arbiter. The master drives payload and valid,
// the slave drives ready.
interface axis_rr_input_arbiter_if #(
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) ();

   logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
   logic [C_AXIS_DATA_WIDTH/8-1:0] tkeep;
   logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
   logic                           tvalid;
   logic                           tlast;
   logic                           tready;

   modport master (
      output tdata,
      output tkeep,
      output tuser,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tuser,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_rr_input_arbiter.sv
// Two-source, packet-granular round-robin arbiter for the P4 wrapper ingress.
// Source 0 is the SUME network path, source 1 the host injection path. The
// owner's beats pass through untouched; a packet is never interleaved with the
// other source. A beat watchdog forces release of a source that streams
// C_MAX_PKT_BEATS beats without tlast.
//
// Optional build macro ARB_STATS_EN adds saturating packet and watchdog-trip
// counters (pkt_cnt0, pkt_cnt1, wdog_cnt) for the AXI-lite register block.
module axis_rr_input_arbiter #(
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_MAX_PKT_BEATS    = 64
) (
   input  logic                            axis_aclk,
   input  logic                            axis_resetn,
   axis_rr_input_arbiter_if.slave          s0_axis,
   axis_rr_input_arbiter_if.slave          s1_axis,
   axis_rr_input_arbiter_if.master         m_axis,
   output logic [1:0]                      grant,
   output logic                            wdog_trip
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]                     pkt_cnt0,
   output logic [31:0]                     pkt_cnt1,
   output logic [15:0]                     wdog_cnt
`endif
);

   localparam int unsigned CntWidth = $clog2(C_MAX_PKT_BEATS) + 1;
   localparam logic [CntWidth-1:0] LastBeat = CntWidth'(C_MAX_PKT_BEATS - 1);

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StG0   = 2'b01,
      StG1   = 2'b10
   } state_e;

   state_e                       state_q, state_d;
   logic                         last_served_q, last_served_d;
   logic [CntWidth-1:0]          beat_cnt_q, beat_cnt_d;
   logic                         wdog_trip_q, wdog_trip_d;

   logic [C_AXIS_DATA_WIDTH-1:0]   m_tdata;
   logic [C_AXIS_DATA_WIDTH/8-1:0] m_tkeep;
   logic [C_AXIS_TUSER_WIDTH-1:0]  m_tuser;
   logic                           m_tvalid;
   logic                           m_tlast;
   logic                           s0_tready;
   logic                           s1_tready;
   logic                           other_valid;
   logic                           own_src;
   logic                           beat_acc;

   // Egress mux and ready steering, selected purely by the registered owner so
   // m_axis.tready never reaches m_axis.tvalid.
   always_comb begin
      m_tdata     = '0;
      m_tkeep     = '0;
      m_tuser     = '0;
      m_tvalid    = 1'b0;
      m_tlast     = 1'b0;
      s0_tready   = 1'b0;
      s1_tready   = 1'b0;
      other_valid = 1'b0;
      own_src     = 1'b0;
      unique case (state_q)
         StG0: begin
            m_tdata     = s0_axis.tdata;
            m_tkeep     = s0_axis.tkeep;
            m_tuser     = s0_axis.tuser;
            m_tvalid    = s0_axis.tvalid;
            m_tlast     = s0_axis.tlast;
            s0_tready   = m_axis.tready;
            other_valid = s1_axis.tvalid;
            own_src     = 1'b0;
         end
         StG1: begin
            m_tdata     = s1_axis.tdata;
            m_tkeep     = s1_axis.tkeep;
            m_tuser     = s1_axis.tuser;
            m_tvalid    = s1_axis.tvalid;
            m_tlast     = s1_axis.tlast;
            s1_tready   = m_axis.tready;
            other_valid = s0_axis.tvalid;
            own_src     = 1'b1;
         end
         default: ;
      endcase
   end

   assign beat_acc = m_tvalid & m_axis.tready;

   assign m_axis.tdata   = m_tdata;
   assign m_axis.tkeep   = m_tkeep;
   assign m_axis.tuser   = m_tuser;
   assign m_axis.tvalid  = m_tvalid;
   assign m_axis.tlast   = m_tlast;
   assign s0_axis.tready = s0_tready;
   assign s1_axis.tready = s1_tready;
   assign grant          = state_q;
   assign wdog_trip      = wdog_trip_q;

   // Arbitration, packet tracking and watchdog next-state logic.
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      beat_cnt_d    = beat_cnt_q;
      wdog_trip_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Tie goes to the source that was not served last.
            if (s0_axis.tvalid && s1_axis.tvalid) begin
               state_d = last_served_q ? StG0 : StG1;
            end else if (s0_axis.tvalid) begin
               state_d = StG0;
            end else if (s1_axis.tvalid) begin
               state_d = StG1;
            end
         end
         StG0, StG1: begin
            if (beat_acc) begin
               if (m_tlast) begin
                  last_served_d = own_src;
                  beat_cnt_d    = '0;
                  if (other_valid) begin
                     state_d = own_src ? StG0 : StG1;
                  end else if (m_tvalid) begin
                     state_d = state_q;
                  end else begin
                     state_d = StIdle;
                  end
               end else if (beat_cnt_q == LastBeat) begin
                  wdog_trip_d   = 1'b1;
                  last_served_d = own_src;
                  beat_cnt_d    = '0;
                  state_d       = StIdle;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end else if (!m_tvalid && (beat_cnt_q == '0)) begin
               // Owner kept the grant after its tlast but has nothing new:
               // release at the packet boundary, handing over if the other
               // side is now waiting.
               state_d = other_valid ? (own_src ? StG0 : StG1) : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         beat_cnt_d = '0;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state_q       <= StIdle;
         last_served_q <= 1'b1;
         beat_cnt_q    <= '0;
         wdog_trip_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         beat_cnt_q    <= beat_cnt_d;
         wdog_trip_q   <= wdog_trip_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [31:0] pkt_cnt0_q;
   logic [31:0] pkt_cnt1_q;
   logic [15:0] wdog_cnt_q;
   logic        eop0;
   logic        eop1;

   assign eop0 = beat_acc & m_tlast & (state_q == StG0);
   assign eop1 = beat_acc & m_tlast & (state_q == StG1);

   // Saturating statistics counters.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
         wdog_cnt_q <= '0;
      end else begin
         if (eop0 && (pkt_cnt0_q != '1)) pkt_cnt0_q <= pkt_cnt0_q + 1'b1;
         if (eop1 && (pkt_cnt1_q != '1)) pkt_cnt1_q <= pkt_cnt1_q + 1'b1;
         if (wdog_trip_d && (wdog_cnt_q != '1)) wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
   assign wdog_cnt = wdog_cnt_q;
`endif

   // Grant is idle or exactly one owner, and only the owner sees ready.
   assert property (@(posedge axis_aclk) disable iff (!axis_resetn) $onehot0(grant));
   assert property (@(posedge axis_aclk) disable iff (!axis_resetn)
                    !(s0_axis.tready && s1_axis.tready));

endmodule

// File: tb/tb_axis_rr_input_arbiter.sv
// Directed bench for the round-robin input arbiter (watchdog limit 4 beats).
module tb_axis_rr_input_arbiter;

   localparam int unsigned DW = 64;
   localparam int unsigned UW = 16;
   localparam int unsigned KW = DW / 8;

   typedef struct packed {
      logic [1:0]    g;
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } obs_t;

   logic axis_aclk = 1'b0;
   logic axis_resetn = 1'b0;
   logic [1:0] grant;
   logic wdog_trip;
`ifdef ARB_STATS_EN
   logic [31:0] pkt_cnt0, pkt_cnt1;
   logic [15:0] wdog_cnt;
`endif

   always #5 axis_aclk = ~axis_aclk;

   axis_rr_input_arbiter_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) s0_if ();
   axis_rr_input_arbiter_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) s1_if ();
   axis_rr_input_arbiter_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) m_if ();

   axis_rr_input_arbiter #(
      .C_AXIS_DATA_WIDTH (DW),
      .C_AXIS_TUSER_WIDTH(UW),
      .C_MAX_PKT_BEATS   (4)
   ) dut (
      .axis_aclk  (axis_aclk),
      .axis_resetn(axis_resetn),
      .s0_axis    (s0_if),
      .s1_axis    (s1_if),
      .m_axis     (m_if),
      .grant      (grant),
      .wdog_trip  (wdog_trip)
`ifdef ARB_STATS_EN
      ,
      .pkt_cnt0   (pkt_cnt0),
      .pkt_cnt1   (pkt_cnt1),
      .wdog_cnt   (wdog_cnt)
`endif
   );

   obs_t q0[$], q1[$], got[$], exp_q[$];
   int   got_cyc[$];
   bit   en0, en1;
   int   cyc_n;
   int   n_cmp, n_err;

   // Beat stimulus: payload fields encode source/packet/index; g is the owner
   // the beat must be seen under at the egress.
   function automatic obs_t mk(input logic [1:0] g, input int src, input int pkt, input int idx,
                               input logic last);
      obs_t o;
      o.g    = g;
      o.data = {16'hCAFE, 16'(src), 16'(pkt), 16'(idx)};
      o.keep = o.data[7:0] ^ 8'h3C;
      o.user = {o.data[23:16], o.data[7:0]} ^ 16'h5A5A;
      o.last = last;
      return o;
   endfunction

   task automatic drive();
      if (en0 && q0.size() > 0) begin
         s0_if.tvalid = 1'b1; s0_if.tdata = q0[0].data; s0_if.tkeep = q0[0].keep;
         s0_if.tuser  = q0[0].user; s0_if.tlast = q0[0].last;
      end else begin
         s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tuser = '0;
         s0_if.tlast  = 1'b0;
      end
      if (en1 && q1.size() > 0) begin
         s1_if.tvalid = 1'b1; s1_if.tdata = q1[0].data; s1_if.tkeep = q1[0].keep;
         s1_if.tuser  = q1[0].user; s1_if.tlast = q1[0].last;
      end else begin
         s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tuser = '0;
         s1_if.tlast  = 1'b0;
      end
   endtask

   task automatic apply();
      drive();
      #1;
   endtask

   // One clock: sample handshakes just before the edge, advance, re-drive.
   task automatic cycle();
      bit   a0, a1;
      obs_t o;
      a0 = s0_if.tvalid & s0_if.tready;
      a1 = s1_if.tvalid & s1_if.tready;
      if (m_if.tvalid && m_if.tready) begin
         o.g = grant; o.data = m_if.tdata; o.keep = m_if.tkeep; o.user = m_if.tuser;
         o.last = m_if.tlast;
         got.push_back(o);
         got_cyc.push_back(cyc_n);
      end
      @(posedge axis_aclk);
      @(negedge axis_aclk);
      cyc_n++;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      drive();
      #1;
   endtask

   task automatic do_reset();
      axis_resetn = 1'b0;
      q0.delete(); q1.delete();
      en0 = 1'b0; en1 = 1'b0;
      m_if.tready = 1'b1;
      apply();
      cycle();
      cycle();
      axis_resetn = 1'b1;
      #1;
      got.delete(); got_cyc.delete();
   endtask

   task automatic test_reset();
      @(negedge axis_aclk);
      axis_resetn = 1'b0;
      m_if.tready = 1'b1;
      q0.push_back(mk(2'b01, 0, 0, 0, 1'b1));
      q1.push_back(mk(2'b10, 1, 0, 0, 1'b1));
      en0 = 1'b1; en1 = 1'b1;
      apply();
      cycle();
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", grant); end
      n_cmp++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_mvalid: got %b want 0", m_if.tvalid); end
      n_cmp++; if ({s0_if.tready, s1_if.tready} !== 2'b00) begin n_err++;
         $display("FAIL reset_tready: got %b want 00", {s0_if.tready, s1_if.tready}); end
      n_cmp++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL reset_wdog: got %b want 0", wdog_trip); end
      q0.delete(); q1.delete(); en0 = 1'b0; en1 = 1'b0;
      apply();
      axis_resetn = 1'b1;
      #1;
      cycle();
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_idle: got %b want 00", grant); end
      n_cmp++; if (dut.beat_cnt_q !== 3'd0) begin n_err++;
         $display("FAIL reset_beatcnt: got %0d want 0", dut.beat_cnt_q); end
      got.delete(); got_cyc.delete();
   endtask

   task automatic test_single_s0();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(2'b01, 0, 1, i, i == 2));
         exp_q.push_back(mk(2'b01, 0, 1, i, i == 2));
      end
      en0 = 1'b1;
      apply();
      n_cmp++; if (grant !== 2'b00 || m_if.tvalid !== 1'b0 || s0_if.tready !== 1'b0) begin n_err++;
         $display("FAIL single_latency: got grant=%b mvalid=%b s0rdy=%b want 00/0/0",
                  grant, m_if.tvalid, s0_if.tready); end
      cycle();
      n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b want 01", grant); end
      n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_q[0].data) begin n_err++;
         $display("FAIL single_first_beat: got v=%b d=%h want v=1 d=%h", m_if.tvalid, m_if.tdata,
                  exp_q[0].data); end
      for (int i = 0; i < 20; i++) begin
         if (q0.size() == 0 && grant == 2'b00) break;
         cycle();
      end
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL single_idle: got %b want 00", grant); end
      n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL single_count: got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++;
            $display("FAIL single_beat%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      en0 = 1'b0;
      got.delete(); got_cyc.delete();
   endtask

   task automatic test_both();
      do_reset();
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(2'b01, 0, 10 + p, i, i == 1));
            q1.push_back(mk(2'b10, 1, 10 + p, i, i == 1));
         end
         for (int i = 0; i < 2; i++) exp_q.push_back(mk(2'b01, 0, 10 + p, i, i == 1));
         for (int i = 0; i < 2; i++) exp_q.push_back(mk(2'b10, 1, 10 + p, i, i == 1));
      end
      en0 = 1'b1; en1 = 1'b1;
      apply();
      for (int i = 0; i < 30; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) break;
         cycle();
      end
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL both_idle: got %b want 00", grant); end
      n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL both_count: got %0d want 8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++;
            $display("FAIL both_beat%0d: got %h want %h", i, got[i], exp_q[i]); end
         n_cmp++; if (got_cyc[i] !== got_cyc[0] + i) begin n_err++;
            $display("FAIL both_nobubble%0d: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
      end
      en0 = 1'b0; en1 = 1'b0;
      got.delete(); got_cyc.delete();
   endtask

   task automatic test_mid_packet();
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         q1.push_back(mk(2'b10, 1, 20, i, i == 3));
         exp_q.push_back(mk(2'b10, 1, 20, i, i == 3));
      end
      for (int i = 0; i < 2; i++) exp_q.push_back(mk(2'b01, 0, 21, i, i == 1));
      en1 = 1'b1;
      apply();
      cycle();
      cycle();
      n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL mid_grant1: got %b want 10", grant); end
      for (int i = 0; i < 2; i++) q0.push_back(mk(2'b01, 0, 21, i, i == 1));
      en0 = 1'b1;
      apply();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (s0_if.tready !== 1'b0) begin n_err++;
            $display("FAIL mid_s0_blocked%0d: got %b want 0", i, s0_if.tready); end
         cycle();
      end
      n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL mid_handover: got %b want 01", grant); end
      for (int i = 0; i < 20; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) break;
         cycle();
      end
      n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL mid_count: got %0d want 6", got.size()); end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++;
            $display("FAIL mid_beat%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      en0 = 1'b0; en1 = 1'b0;
      got.delete(); got_cyc.delete();
   endtask

   task automatic test_stall();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(2'b01, 0, 30, i, i == 2));
         exp_q.push_back(mk(2'b01, 0, 30, i, i == 2));
      end
      en0 = 1'b1;
      m_if.tready = 1'b1;
      apply();
      cycle();
      cycle();
      m_if.tready = 1'b0;
      apply();
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_q[1].data ||
                      m_if.tuser !== exp_q[1].user || m_if.tlast !== 1'b0) begin n_err++;
            $display("FAIL stall_hold%0d: got v=%b d=%h u=%h l=%b want v=1 d=%h u=%h l=0", i,
                     m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast, exp_q[1].data, exp_q[1].user); end
         n_cmp++; if (dut.beat_cnt_q !== 3'd1) begin n_err++;
            $display("FAIL stall_beatcnt%0d: got %0d want 1", i, dut.beat_cnt_q); end
         cycle();
      end
      m_if.tready = 1'b1;
      apply();
      cycle();
      n_cmp++; if (dut.beat_cnt_q !== 3'd2) begin n_err++;
         $display("FAIL stall_resume_cnt: got %0d want 2", dut.beat_cnt_q); end
      for (int i = 0; i < 20; i++) begin
         if (q0.size() == 0 && grant == 2'b00) break;
         cycle();
      end
      n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL stall_count: got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== exp_q[i]) begin n_err++;
            $display("FAIL stall_beat%0d: got %h want %h", i, got[i], exp_q[i]); end
      end
      en0 = 1'b0;
      got.delete(); got_cyc.delete();
   endtask

   task automatic test_watchdog();
      for (int i = 0; i < 6; i++) q1.push_back(mk(2'b10, 1, 40, i, 1'b0));
      en1 = 1'b1;
      apply();
      cycle();
      cycle();
      cycle();
      q0.push_back(mk(2'b01, 0, 41, 0, 1'b1));
      en0 = 1'b1;
      apply();
      n_cmp++; if (s0_if.tready !== 1'b0) begin n_err++; $display("FAIL wdog_s0_wait: got %b want 0", s0_if.tready); end
      cycle();
      n_cmp++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL wdog_early: got %b want 0", wdog_trip); end
      cycle();
      n_cmp++; if (wdog_trip !== 1'b1) begin n_err++; $display("FAIL wdog_pulse: got %b want 1", wdog_trip); end
      n_cmp++; if (grant !== 2'b00 || s1_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin n_err++;
         $display("FAIL wdog_release: got grant=%b s1rdy=%b mvalid=%b want 00/0/0",
                  grant, s1_if.tready, m_if.tvalid); end
      n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL wdog_beats: got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== mk(2'b10, 1, 40, i, 1'b0)) begin n_err++;
            $display("FAIL wdog_beat%0d: got %h want %h", i, got[i], mk(2'b10, 1, 40, i, 1'b0)); end
      end
      cycle();
      n_cmp++; if (grant !== 2'b01 || wdog_trip !== 1'b0 || s1_if.tready !== 1'b0) begin n_err++;
         $display("FAIL wdog_next_grant: got grant=%b trip=%b s1rdy=%b want 01/0/0",
                  grant, wdog_trip, s1_if.tready); end
      cycle();
      n_cmp++; if (got.size() != 5 || got[got.size()-1] !== mk(2'b01, 0, 41, 0, 1'b1)) begin n_err++;
         $display("FAIL wdog_s0_pkt: got n=%0d last=%h want n=5 last=%h", got.size(),
                  got[got.size()-1], mk(2'b01, 0, 41, 0, 1'b1)); end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      for (int i = 0; i < 3; i++) q0.push_back(mk(2'b01, 0, 50, i, i == 2));
      en0 = 1'b1;
      apply();
      cycle();
      cycle();
      n_cmp++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== mk(2'b01, 0, 50, 1, 1'b0).data) begin n_err++;
         $display("FAIL rstmid_beat2: got v=%b d=%h want v=1 d=%h", m_if.tvalid, m_if.tdata,
                  mk(2'b01, 0, 50, 1, 1'b0).data); end
      axis_resetn = 1'b0;
      #1;
      n_cmp++; if (m_if.tvalid !== 1'b0 || s0_if.tready !== 1'b0 || s1_if.tready !== 1'b0 ||
                   grant !== 2'b00) begin n_err++;
         $display("FAIL rstmid_outputs: got mvalid=%b s0rdy=%b s1rdy=%b grant=%b want 0/0/0/00",
                  m_if.tvalid, s0_if.tready, s1_if.tready, grant); end
      q0.delete(); q1.delete();
      q0.push_back(mk(2'b01, 0, 51, 0, 1'b1));
      q1.push_back(mk(2'b10, 1, 51, 0, 1'b1));
      en1 = 1'b1;
      apply();
      cycle();
      axis_resetn = 1'b1;
      #1;
      cycle();
      n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL rstmid_first_grant: got %b want 01", grant); end
      for (int i = 0; i < 20; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00) break;
         cycle();
      end
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rstmid_drain: got %b want 00", grant); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc_n = 0;
      en0 = 1'b0;
      en1 = 1'b0;
      m_if.tready = 1'b1;
      drive();
      test_reset();
      test_single_s0();
      test_both();
      test_mid_packet();
      test_stall();
      test_watchdog();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/axis_rr_input_arbiter.md
Name: axis_rr_input_arbiter

Overview:
- Two-source, packet-granular round-robin arbiter on the AXI-Stream ingress of the P4 processor wrapper.
- Source 0 is the SUME network path. Source 1 is a host/CPU injection path.
- Merges both sources into the single packet_in stream. A packet is never interleaved with the other source.
- tdata, tkeep, tuser and tlast of the granted source pass through unmodified, so the downstream tuple FSM sees one well-formed packet at a time.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width for both slave ports and the master port.
- C_AXIS_TUSER_WIDTH, 128, tuser width (SUME metadata).
- C_MAX_PKT_BEATS, 64, beat limit per packet before the watchdog forces release.

Ports:
- axis_aclk  in  1  stream clock.
- axis_resetn  in  1  asynchronous active-low reset.
- s0_axis_tdata / s1_axis_tdata  in  C_AXIS_DATA_WIDTH  source data.
- s0_axis_tkeep / s1_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables.
- s0_axis_tuser / s1_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata.
- s0_axis_tvalid / s1_axis_tvalid  in  1  source valid.
- s0_axis_tlast / s1_axis_tlast  in  1  end of packet.
- s0_axis_tready / s1_axis_tready  out  1  source ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  merged byte enables.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged metadata.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tready  in  1  downstream ready.
- grant  out  2  one-hot current owner; 00 = idle.
- wdog_trip  out  1  one-cycle pulse when the watchdog forces release.

Behaviour:
- Clock and reset: axis_aclk is the only clock. axis_resetn is asynchronous and active-low. Asserting it clears all state immediately; release is synchronous to axis_aclk.
- Reset values: state=IDLE, grant=00, last_served=1 (source 0 wins first), beat_cnt=0, wdog_trip=0. With state=IDLE: m_axis_tvalid=0, s0_axis_tready=0, s1_axis_tready=0.
- States: IDLE, G0, G1. The state is registered. Data, valid and ready are combinational muxes selected by the state.
- IDLE:
  - Either tvalid high → next state is the requester that did not match last_served, if it is requesting; otherwise the one requesting.
  - Both requesting → the source other than last_served wins.
  - Arbitration latency: one cycle from first tvalid to grant.
- Gx (x = 0 or 1):
  - m_axis_* = sx_axis_*.
  - m_axis_tvalid = sx_axis_tvalid.
  - sx_axis_tready = m_axis_tready; the other tready = 0.
  - A beat is accepted when sx_tvalid & m_tready.
- End of packet (accepted beat with tlast=1):
  - last_served ← x.
  - Other source's tvalid high in the same cycle → go directly to G(other); no bubble.
  - Else own tvalid still high → stay in Gx.
  - Else → IDLE.
- beat_cnt:
  - Increments on every accepted beat; clears on an accepted tlast beat and on any grant change.
  - Counter width is clog2(C_MAX_PKT_BEATS)+1; it never wraps.
- Watchdog:
  - Triggers when the C_MAX_PKT_BEATS-th accepted beat is not tlast.
  - Arbiter pulses wdog_trip for one cycle, sets last_served ← x, and goes to IDLE.
  - The offending source keeps tready low until it re-wins arbitration.
  - Downstream sees a truncated packet; dropping it is the downstream's responsibility.
- tready/tvalid compliance: no combinational path from m_axis_tready to m_axis_tvalid. Outputs hold stable while tvalid=1 and tready=0.
- Reset mid-packet: outputs drop to reset values in the same cycle. The partially sent packet is truncated; no recovery is attempted.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs pkt_cnt0 and pkt_cnt1 (32 bits each) and wdog_cnt (16 bits).
  - Each counter increments on an accepted tlast beat (or on a trip, for wdog_cnt).
  - Counters saturate at all-ones and reset to 0.
  - Readout goes through the control AXI-lite register block.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then s0 sends a 3-beat packet with m_tready=1 → grant=01 one cycle after tvalid. Three beats emerge with identical tdata/tuser/tkeep; then IDLE, grant=00.
- s0 and s1 both assert tvalid in the same cycle, 2-beat packets each, continuously → order s0, s1, s0, s1. There is no idle cycle between packets once arbitration has started.
- s1 mid-packet (beat 2 of 4) while s0 raises tvalid → s0_tready stays 0 until s1 tlast is accepted, then grant=01 on the next cycle.
- m_tready toggles 1,0,0,1 during a G0 packet → m_axis_* hold stable while stalled. No beat is lost or duplicated; beat_cnt increments only on accepted beats.
- C_MAX_PKT_BEATS=4, s1 streams 6 beats without tlast → wdog_trip pulses after the 4th accepted beat, grant=00, and a pending s0 is granted next.
- axis_resetn asserted during beat 2 of an s0 packet → m_axis_tvalid=0 and both treadies=0 immediately. After release, the first grant goes to s0 when both request.
